// File: rtl/wb_hazard_scoreboard_pkg.sv
// Shared register-index constants and helpers for the writeback scoreboard.
// Only the register-file geometry lives here; opcode decode stays in the decode stage.
package wb_hazard_scoreboard_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // x0 is hardwired to zero, so it never carries a pending write.
    function automatic logic is_tracked(input reg_idx_t idx);
        return idx != '0;
    endfunction

endpackage

// File: rtl/wb_pend_counter.sv
// Per-register outstanding-write counter: up on issue, down on retire, saturating at both ends.
module wb_pend_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero,
    output logic             max
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec && !max) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc && !zero) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);
    assign max  = (cnt_q == '1);

    // A retire with nothing outstanding means the pipeline lost track of an instruction.
    underflow_chk : assert property (@(posedge clk) disable iff (rst) !(dec && zero))
        else $error("wb_pend_counter: retire with no pending write");

endmodule

// File: rtl/wb_hazard_scoreboard.sv
// Writeback scoreboard for the non-forwarding RV32I pipeline: RAW/overflow stall,
// pending-write mask and a saturating stall-cycle counter.
module wb_hazard_scoreboard
    import wb_hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W     = 2,
    parameter int WB_BYPASS = 1,
    parameter int PERF_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic                 issue_wb,
    input  logic [REG_IDX_W-1:0] issue_rs1,
    input  logic [REG_IDX_W-1:0] issue_rs2,
    input  logic                 issue_use_rs1,
    input  logic                 issue_use_rs2,
    input  logic                 retire_valid,
    input  logic [REG_IDX_W-1:0] retire_rd,
    input  logic                 retire_wb,
    output logic                 issue_stall,
    output logic [NUM_REGS-1:0]  pending_mask,
    output logic [PERF_W-1:0]    stall_cycles
);

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] zero_vec;
    logic [NUM_REGS-1:0] max_vec;

    logic issue_fire;
    logic retire_fire;
    logic land_rs1, land_rs2;
    logic hz_rs1, hz_rs2, ovf;

    logic [PERF_W-1:0] stall_cycles_q;
    logic [PERF_W-1:0] stall_cycles_d;

    // x0 slot is a constant "nothing pending" so variable indexing needs no special case.
    assign cnt[0]      = '0;
    assign zero_vec[0] = 1'b1;
    assign max_vec[0]  = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        logic inc_r;
        logic dec_r;

        assign inc_r = issue_fire  && (issue_rd  == reg_idx_t'(r));
        assign dec_r = retire_fire && (retire_rd == reg_idx_t'(r));

        wb_pend_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .inc  (inc_r),
            .dec  (dec_r),
            .cnt  (cnt[r]),
            .zero (zero_vec[r]),
            .max  (max_vec[r])
        );
    end

    assign retire_fire = retire_valid && retire_wb && is_tracked(retire_rd);

    // With a write-through regfile the last pending write landing this cycle is visible to the reader.
    assign land_rs1 = (WB_BYPASS != 0) && (cnt[issue_rs1] == CNT_W'(1))
                      && retire_fire && (retire_rd == issue_rs1);
    assign land_rs2 = (WB_BYPASS != 0) && (cnt[issue_rs2] == CNT_W'(1))
                      && retire_fire && (retire_rd == issue_rs2);

    assign hz_rs1 = issue_use_rs1 && is_tracked(issue_rs1) && !zero_vec[issue_rs1] && !land_rs1;
    assign hz_rs2 = issue_use_rs2 && is_tracked(issue_rs2) && !zero_vec[issue_rs2] && !land_rs2;

    assign ovf = issue_wb && is_tracked(issue_rd) && max_vec[issue_rd]
                 && !(retire_fire && (retire_rd == issue_rd));

    assign issue_stall = issue_valid && (hz_rs1 || hz_rs2 || ovf);
    assign issue_fire  = issue_valid && !issue_stall && issue_wb && is_tracked(issue_rd);

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (issue_valid && issue_stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign pending_mask = ~zero_vec;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_wb_hazard_scoreboard.sv
// Randomized scoreboard bench: the model tracks in-flight writers as a queue of rd values.
module tb_wb_hazard_scoreboard;

    localparam int PW       = 6;
    localparam int PERF_MAX = (1 << PW) - 1;
    localparam int CNT_MAX  = 3;
    localparam bit BYP      = 1'b1;

    typedef struct packed {
        logic          stall;
        logic [31:0]   mask;
        logic [PW-1:0] perf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid, issue_wb, issue_use_rs1, issue_use_rs2;
    logic [4:0]    issue_rd, issue_rs1, issue_rs2;
    logic          retire_valid, retire_wb;
    logic [4:0]    retire_rd;
    logic          issue_stall;
    logic [31:0]   pending_mask;
    logic [PW-1:0] stall_cycles;

    int vectors    = 0;
    int miscompares = 0;

    exp_t       exp_q[$];
    logic [4:0] inflight[$];
    int         perf = 0;

    wb_hazard_scoreboard #(
        .CNT_W     (2),
        .WB_BYPASS (1),
        .PERF_W    (PW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_wb      (issue_wb),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_use_rs1 (issue_use_rs1),
        .issue_use_rs2 (issue_use_rs2),
        .retire_valid  (retire_valid),
        .retire_rd     (retire_rd),
        .retire_wb     (retire_wb),
        .issue_stall   (issue_stall),
        .pending_mask  (pending_mask),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int pend(input logic [4:0] r);
        int n = 0;
        foreach (inflight[i]) if (inflight[i] == r) n++;
        return n;
    endfunction

    // One clock of stimulus: drive, predict, enqueue the prediction, advance the model.
    task automatic drive(input logic iv, input logic [4:0] ird, input logic iwb,
                         input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                         input logic rv, input logic [4:0] rrd, input logic rwb);
        exp_t e;
        logic rfire, h1, h2, ovf, stall;
        int   c1, c2;
        @(negedge clk);
        issue_valid = iv;  issue_rd = ird;  issue_wb = iwb;
        issue_rs1 = r1;    issue_use_rs1 = u1;
        issue_rs2 = r2;    issue_use_rs2 = u2;
        retire_valid = rv; retire_rd = rrd; retire_wb = rwb;
        rfire = rv && rwb && (rrd != 0);
        c1 = pend(r1);
        c2 = pend(r2);
        h1 = u1 && (r1 != 0) && (c1 != 0) && !(BYP && c1 == 1 && rfire && rrd == r1);
        h2 = u2 && (r2 != 0) && (c2 != 0) && !(BYP && c2 == 1 && rfire && rrd == r2);
        ovf = iwb && (ird != 0) && (pend(ird) == CNT_MAX) && !(rfire && rrd == ird);
        stall = iv && (h1 || h2 || ovf);
        e.stall = stall;
        e.mask  = '0;
        for (int r = 1; r < 32; r++) e.mask[r] = (pend(5'(r)) != 0);
        e.perf = PW'(perf);
        exp_q.push_back(e);
        if (iv && stall && perf < PERF_MAX) perf++;
        if (rfire) begin
            for (int i = 0; i < inflight.size(); i++) begin
                if (inflight[i] == rrd) begin
                    inflight.delete(i);
                    break;
                end
            end
        end
        if (iv && !stall && iwb && ird != 0) inflight.push_back(ird);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic use_rs1(input logic [4:0] r);
        drive(1, 0, 0, r, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic retire(input logic [4:0] r);
        drive(0, 0, 0, 0, 0, 0, 0, 1, r, 1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("issue_stall",  64'(issue_stall),  64'(e.stall));
                chk("pending_mask", 64'(pending_mask), 64'(e.mask));
                chk("stall_cycles", 64'(stall_cycles), 64'(e.perf));
            end
        end
    end

    initial begin : stim
        logic [4:0] rrd_r;
        issue_valid = 0; issue_rd = 0; issue_wb = 0;
        issue_rs1 = 0; issue_rs2 = 0; issue_use_rs1 = 0; issue_use_rs2 = 0;
        retire_valid = 0; retire_rd = 0; retire_wb = 0;
        rst = 1'b1;
        #3;
        chk("reset_stall", 64'(issue_stall), 64'd0);
        chk("reset_mask",  64'(pending_mask), 64'd0);
        chk("reset_perf",  64'(stall_cycles), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // RAW on x5, released by the bypassed retire
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        use_rs1(5);
        use_rs1(5);
        drive(1, 6, 1, 5, 1, 0, 0, 1, 5, 1);
        retire(6);

        // x0 is never tracked
        repeat (3) drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 1, 0, 1, 1, 0, 1);
        idle();

        // overflow on x7 and the same-cycle retire that relieves it
        repeat (3) drive(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 7, 1, 0, 0, 0, 0, 1, 7, 1);
        idle();
        repeat (3) retire(7);

        // simultaneous issue and retire of x9 holds the count
        drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 9, 1, 0, 0, 0, 0, 1, 9, 1);
        idle();
        retire(9);
        idle();

        // asynchronous reset in the middle of a stall on x4
        drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
        use_rs1(4);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_stall", 64'(issue_stall),  64'd0);
        chk("async_rst_mask",  64'(pending_mask), 64'd0);
        chk("async_rst_perf",  64'(stall_cycles), 64'd0);
        inflight.delete();
        perf = 0;
        @(negedge clk);
        issue_valid = 0;
        rst = 1'b0;

        // load-use with four stalled cycles
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) use_rs1(3);
        idle();
        #3;
        chk("perf_four", 64'(stall_cycles), 64'd4);
        retire(3);

        for (int n = 0; n < 1500; n++) begin
            logic iv, iwb, u1, u2, rv, rwb;
            logic [4:0] ird, r1, r2;
            iv  = (inflight.size() < 10) && ($urandom_range(0, 3) != 0);
            ird = 5'($urandom_range(0, 7));
            iwb = ($urandom_range(0, 3) != 0);
            r1  = 5'($urandom_range(0, 7));
            r2  = 5'($urandom_range(0, 7));
            u1  = 1'($urandom_range(0, 1));
            u2  = 1'($urandom_range(0, 1));
            rrd_r = 5'($urandom_range(1, 31));
            if (inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
                rv = 1; rwb = 1; rrd_r = inflight[0];
            end else if ($urandom_range(0, 3) == 0) begin
                rv = 1; rwb = 1'($urandom_range(0, 1));
                if (rwb) rrd_r = 5'd0;
            end else begin
                rv = 0; rwb = 1'($urandom_range(0, 1));
            end
            drive(iv, ird, iwb, r1, u1, r2, u2, rv, rrd_r, rwb);
        end
        while (inflight.size() > 0) retire(inflight[0]);

        // drive the perf counter past its ceiling
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        repeat (PERF_MAX + 8) use_rs1(3);
        idle();
        #3;
        chk("perf_saturate", 64'(stall_cycles), 64'(PERF_MAX));
        retire(3);
        idle();
        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
